// File: rtl/ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_pkg
//   Shared constants and types for the execute stage: bus widths, one-hot
//   opcode bit positions, the packed layouts of the decode->EX bundle, the
//   EX->MEM bundle and the forwarding bus, the divider state encoding and a
//   small two's-complement helper.
// ---------------------------------------------------------------------------
package ex_stage_pkg;

    localparam int TO_EX_DATA_WIDTH   = 157;
    localparam int TO_MEM_DATA_WIDTH  = 74;
    localparam int FORWARD_DATA_WIDTH = 38;

    localparam int DIV_STEPS_DEFAULT  = 32;

    // alu_op one-hot bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // div_op one-hot bit positions
    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    // mem_we bit positions (store size)
    localparam int MEM_B = 0;
    localparam int MEM_H = 1;
    localparam int MEM_W = 2;

    // read_mem bit positions (load size + sign extension request)
    localparam int RD_B      = 0;
    localparam int RD_H      = 1;
    localparam int RD_W      = 2;
    localparam int RD_SIGNED = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [3:0]  div_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store_data;
        logic [2:0]  mem_we;
        logic [3:0]  read_mem;
        logic [4:0]  dest;
        logic        gr_we;
    } ex_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [3:0]  read_mem;
        logic [4:0]  dest;
        logic        gr_we;
    } mem_bundle_t;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] result;
        logic        not_ready;
    } fwd_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when en is set, pass-through otherwise.
    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// ex_stage_if
//   Bundles every non-clock signal of the execute stage.
//   master : the surrounding pipeline (decode + MEM + data SRAM side);
//            drives ID_to_EX_valid, to_EX_data, MEM_allow_in.
//   slave  : the execute stage; drives the handshake back to decode, the
//            bundle to MEM, the data-SRAM request and the forwarding bus.
// ---------------------------------------------------------------------------
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic                          MEM_allow_in;
    logic                          ID_to_EX_valid;
    logic [TO_EX_DATA_WIDTH-1:0]   to_EX_data;
    logic                          EX_allow_in;
    logic                          EX_to_MEM_valid;
    logic [TO_MEM_DATA_WIDTH-1:0]  to_MEM_data;
    logic                          data_sram_en;
    logic [3:0]                    data_sram_we;
    logic [31:0]                   data_sram_addr;
    logic [31:0]                   data_sram_wdata;
    logic [FORWARD_DATA_WIDTH-1:0] EX_forward;

    modport master (
        output MEM_allow_in, ID_to_EX_valid, to_EX_data,
        input  EX_allow_in, EX_to_MEM_valid, to_MEM_data,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               EX_forward
    );

    modport slave (
        input  MEM_allow_in, ID_to_EX_valid, to_EX_data,
        output EX_allow_in, EX_to_MEM_valid, to_MEM_data,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
               EX_forward
    );

endinterface

// File: rtl/ex_stage_div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative restoring divider, one quotient bit per cycle.
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a division (sampled only in IDLE)
//   is_signed        : operands are two's-complement
//   dividend/divisor : operands, sampled on start
//   ack              : consumer has taken the result (leaves DONE)
//   done             : quotient/remainder valid and held
//   quotient/remainder
// Divide by zero yields quotient all-ones and remainder = dividend.
// ---------------------------------------------------------------------------
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(DIV_STEPS + 1);

    div_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] quo_q, quo_d;     // dividend shifts out the top, quotient bits shift in
    logic [31:0] rem_q, rem_d;     // partial remainder
    logic [31:0] dsr_q, dsr_d;     // divisor magnitude
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [32:0] trial;
    logic [33:0] diff;
    logic        ge;

    assign trial = {rem_q, quo_q[31]};
    assign diff  = {1'b0, trial} - {2'b00, dsr_q};
    assign ge    = ~diff[33];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d   = DIV_BUSY;
                    count_d   = CW'(DIV_STEPS);
                    quo_d     = negate_if(dividend, is_signed & dividend[31]);
                    dsr_d     = negate_if(divisor, is_signed & divisor[31]);
                    rem_d     = '0;
                    // Divide-by-zero keeps the all-ones quotient regardless of sign.
                    neg_quo_d = is_signed & (dividend[31] ^ divisor[31]) & (|divisor);
                    neg_rem_d = is_signed & dividend[31];
                end
            end
            DIV_BUSY: begin
                quo_d   = {quo_q[30:0], ge};
                rem_d   = ge ? diff[31:0] : trial[31:0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together
    // from values computed before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the datapath is deliberately not reset; it is always loaded on
    // start before anything reads it, and leaving it out of reset keeps the
    // reset network small.
    always_ff @(posedge clk) begin
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        dsr_q     <= dsr_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign done      = (state_q == DIV_DONE);
    assign quotient  = negate_if(quo_q, neg_quo_q);
    assign remainder = negate_if(rem_q, neg_rem_q);

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 5-stage in-order pipeline.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : ex_stage_if.slave
//     in  MEM_allow_in, ID_to_EX_valid, to_EX_data[156:0]
//     out EX_allow_in, EX_to_MEM_valid, to_MEM_data[73:0],
//         data_sram_en/we/addr/wdata, EX_forward[37:0]
//   Holds one bundle, computes the ALU result combinationally, runs div/mod
//   through div_unit, issues the data-SRAM request in the cycle the bundle
//   advances to MEM, and drives the forwarding bus back to decode.
// ---------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    ex_stage_if.slave  bus
);

    logic       ex_valid_q, ex_valid_d;
    ex_bundle_t bundle_q, bundle_d;
    ex_bundle_t in_bundle;

    logic is_div, div_signed, div_sel_rem, div_sel_quo;
    logic div_done, ex_ready_go, ex_allow_in;
    logic [31:0] quotient, remainder;

    assign in_bundle = bus.to_EX_data;

    // ---------------- handshake + bundle register ----------------
    assign is_div      = |bundle_q.div_op;
    assign div_signed  = bundle_q.div_op[DIV_W] | bundle_q.div_op[MOD_W];
    assign div_sel_quo = bundle_q.div_op[DIV_W] | bundle_q.div_op[DIV_WU];
    assign div_sel_rem = bundle_q.div_op[MOD_W] | bundle_q.div_op[MOD_WU];

    assign ex_ready_go = ~is_div | div_done;
    assign ex_allow_in = ~ex_valid_q | (ex_ready_go & bus.MEM_allow_in);

    always_comb begin
        ex_valid_d = ex_valid_q;
        bundle_d   = bundle_q;
        if (ex_allow_in) begin
            ex_valid_d = bus.ID_to_EX_valid;
        end
        if (ex_allow_in & bus.ID_to_EX_valid) begin
            bundle_d = in_bundle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        bundle_q <= bundle_d;
    end

    assign bus.EX_allow_in     = ex_allow_in;
    assign bus.EX_to_MEM_valid = ex_valid_q & ex_ready_go;

    // ---------------- ALU ----------------
    logic [31:0] src1, src2, alu_sum, alu_diff, alu_result;
    logic [4:0]  shamt;
    logic [11:0] op;

    assign src1     = bundle_q.src1;
    assign src2     = bundle_q.src2;
    assign op       = bundle_q.alu_op;
    assign shamt    = src2[4:0];
    assign alu_sum  = src1 + src2;
    assign alu_diff = src1 - src2;

    // alu_op is one-hot, so an AND-OR mux selects the result.
    assign alu_result =
          ({32{op[ALU_ADD]}}  & alu_sum)
        | ({32{op[ALU_SUB]}}  & alu_diff)
        | ({32{op[ALU_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
        | ({32{op[ALU_SLTU]}} & {31'd0, src1 < src2})
        | ({32{op[ALU_AND]}}  & (src1 & src2))
        | ({32{op[ALU_NOR]}}  & ~(src1 | src2))
        | ({32{op[ALU_OR]}}   & (src1 | src2))
        | ({32{op[ALU_XOR]}}  & (src1 ^ src2))
        | ({32{op[ALU_SLL]}}  & (src1 << shamt))
        | ({32{op[ALU_SRL]}}  & (src1 >> shamt))
        | ({32{op[ALU_SRA]}}  & $unsigned($signed(src1) >>> shamt))
        | ({32{op[ALU_LUI]}}  & src2);

    // ---------------- divider ----------------
    div_unit #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_valid_q & is_div),
        .is_signed (div_signed),
        .dividend  (src1),
        .divisor   (src2),
        .ack       (ex_ready_go & bus.MEM_allow_in),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    logic [31:0] result;
    assign result = div_sel_quo ? quotient :
                    div_sel_rem ? remainder : alu_result;

    // ---------------- data SRAM request ----------------
    logic is_load, is_store, sram_en;
    logic [3:0]  we_raw;
    logic [31:0] wdata;

    assign is_load  = |bundle_q.read_mem[RD_W:RD_B];
    assign is_store = |bundle_q.mem_we;
    // Memory ops never stall in EX, so gating with MEM_allow_in fires the
    // request exactly once: in the cycle the bundle moves to MEM.
    assign sram_en  = ex_valid_q & (is_load | is_store) & bus.MEM_allow_in;

    always_comb begin
        we_raw = 4'b0000;
        wdata  = bundle_q.store_data;
        if (bundle_q.mem_we[MEM_B]) begin
            we_raw = 4'b0001 << alu_sum[1:0];
            wdata  = {4{bundle_q.store_data[7:0]}};
        end else if (bundle_q.mem_we[MEM_H]) begin
            we_raw = alu_sum[1] ? 4'b1100 : 4'b0011;
            wdata  = {2{bundle_q.store_data[15:0]}};
        end else if (bundle_q.mem_we[MEM_W]) begin
            we_raw = 4'b1111;
        end
    end

    assign bus.data_sram_en    = sram_en;
    assign bus.data_sram_we    = sram_en ? we_raw : 4'b0000;
    assign bus.data_sram_addr  = alu_sum;
    assign bus.data_sram_wdata = wdata;

    // ---------------- to MEM / forwarding ----------------
    mem_bundle_t to_mem;
    fwd_bus_t    fwd;

    always_comb begin
        to_mem.pc       = bundle_q.pc;
        to_mem.result   = result;
        to_mem.read_mem = bundle_q.read_mem;
        to_mem.dest     = bundle_q.dest;
        to_mem.gr_we    = bundle_q.gr_we;

        fwd.dest      = bundle_q.dest & {5{ex_valid_q & bundle_q.gr_we}};
        fwd.result    = result;
        // Load data and an unfinished quotient are not available yet.
        fwd.not_ready = ex_valid_q & (is_load | (is_div & ~div_done));
    end

    assign bus.to_MEM_data = to_mem;
    assign bus.EX_forward  = fwd;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_bundle_t mb;
    fwd_bus_t    fb;
    assign mb = bus.to_MEM_data;
    assign fb = bus.EX_forward;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic ex_bundle_t mk(input int alu, input int dv,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] sd, input logic [2:0] mw,
                                      input logic [3:0] rm, input logic [4:0] dest);
        ex_bundle_t r;
        r = '0;
        r.pc = 32'h1c00_0000;
        if (alu >= 0) r.alu_op[alu] = 1'b1;
        if (dv >= 0)  r.div_op[dv]  = 1'b1;
        r.src1       = a;
        r.src2       = b;
        r.store_data = sd;
        r.mem_we     = mw;
        r.read_mem   = rm;
        r.dest       = dest;
        r.gr_we      = (dest != 5'd0);
        return r;
    endfunction

    // Called at a negedge; returns at the next negedge with the bundle in EX.
    task automatic issue(input ex_bundle_t b);
        bus.ID_to_EX_valid = 1'b1;
        bus.to_EX_data     = b;
        @(negedge clk);
        bus.ID_to_EX_valid = 1'b0;
    endtask

    task automatic run_div(input string tag, input int dv,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        cyc = 0;
        issue(mk(-1, dv, a, b, 32'd0, 3'b000, 4'b0000, 5'd4));
        check({tag, "_nr_busy"}, 32'(fb.not_ready), 32'd1);
        while (!bus.EX_allow_in && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 32'(cyc), 32'd33);
        check(tag, mb.result, exp);
        check({tag, "_valid"}, 32'(bus.EX_to_MEM_valid), 32'd1);
        check({tag, "_nr_done"}, 32'(fb.not_ready), 32'd0);
    endtask

    int          alu_op_tab [10] = '{ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SLL,
                                     ALU_NOR, ALU_SRL, ALU_XOR, ALU_LUI, ALU_AND};
    logic [31:0] alu_a_tab  [10] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd1,
                                     32'h0F0F0000, 32'h80000000, 32'hFF00FF00, 32'd0, 32'hFF00FF00};
    logic [31:0] alu_b_tab  [10] = '{32'd7, 32'd1, 32'd1, 32'd4, 32'h3F,
                                     32'h00000F0F, 32'd4, 32'h0F0F0F0F, 32'h12345000, 32'h0F0F0F0F};
    logic [31:0] alu_e_tab  [10] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h80000000,
                                     32'hF0F0F0F0, 32'h08000000, 32'hF00FF00F, 32'h12345000, 32'h0F000F00};

    initial begin
        bus.MEM_allow_in   = 1'b1;
        bus.ID_to_EX_valid = 1'b0;
        bus.to_EX_data     = '0;
        reset              = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_valid", 32'(bus.EX_to_MEM_valid), 32'd0);
        check("rst_en", 32'(bus.data_sram_en), 32'd0);
        check("rst_we", 32'(bus.data_sram_we), 32'd0);
        check("rst_fwd_dest", 32'(fb.dest), 32'd0);
        check("rst_allow_in", 32'(bus.EX_allow_in), 32'd1);
        reset = 1'b0;

        // add 5 + 7
        issue(mk(ALU_ADD, -1, 32'd5, 32'd7, 32'd0, 3'b000, 4'b0000, 5'd3));
        check("add_result", mb.result, 32'd12);
        check("add_valid", 32'(bus.EX_to_MEM_valid), 32'd1);
        check("add_allow_in", 32'(bus.EX_allow_in), 32'd1);
        check("add_fwd_dest", 32'(fb.dest), 32'd3);
        check("add_fwd_nr", 32'(fb.not_ready), 32'd0);
        check("add_no_en", 32'(bus.data_sram_en), 32'd0);
        @(negedge clk);
        check("add_drained", 32'(bus.EX_to_MEM_valid), 32'd0);

        // ALU table, issued back to back
        for (int i = 0; i < 10; i++) begin
            issue(mk(alu_op_tab[i], -1, alu_a_tab[i], alu_b_tab[i], 32'd0, 3'b000, 4'b0000, 5'd1));
            check($sformatf("alu_%0d", i), mb.result, alu_e_tab[i]);
        end
        @(negedge clk);

        // dividers, back to back
        run_div("divw_m7_2",   DIV_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run_div("modw_m7_2",   MOD_W,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run_div("divwu_10_0",  DIV_WU, 32'd10,       32'd0,        32'hFFFFFFFF);
        run_div("modwu_10_0",  MOD_WU, 32'd10,       32'd0,        32'd10);
        run_div("divw_ovf",    DIV_W,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_div("modw_ovf",    MOD_W,  32'h80000000, 32'hFFFFFFFF, 32'd0);
        run_div("divw_7_m2",   DIV_W,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        run_div("modw_7_m2",   MOD_W,  32'd7,        32'hFFFFFFFE, 32'd1);
        run_div("divwu_big",   DIV_WU, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF);
        run_div("modwu_100_7", MOD_WU, 32'd100,      32'd7,        32'd2);
        @(negedge clk);

        // stores
        issue(mk(ALU_ADD, -1, 32'h1000, 32'd3, 32'h000000AB, 3'b001, 4'b0000, 5'd0));
        check("stb_en", 32'(bus.data_sram_en), 32'd1);
        check("stb_we", 32'(bus.data_sram_we), 32'b1000);
        check("stb_wdata", bus.data_sram_wdata, 32'hABABABAB);
        check("stb_addr", bus.data_sram_addr, 32'h1003);
        @(negedge clk);
        check("stb_en_once", 32'(bus.data_sram_en), 32'd0);

        issue(mk(ALU_ADD, -1, 32'h1000, 32'd2, 32'h00001234, 3'b010, 4'b0000, 5'd0));
        check("sth_we", 32'(bus.data_sram_we), 32'b1100);
        check("sth_wdata", bus.data_sram_wdata, 32'h12341234);
        @(negedge clk);

        issue(mk(ALU_ADD, -1, 32'h1000, 32'd0, 32'hDEADBEEF, 3'b100, 4'b0000, 5'd0));
        check("stw_we", 32'(bus.data_sram_we), 32'b1111);
        check("stw_wdata", bus.data_sram_wdata, 32'hDEADBEEF);
        @(negedge clk);

        // load held by MEM for 3 cycles
        bus.MEM_allow_in = 1'b0;
        issue(mk(ALU_ADD, -1, 32'h2000, 32'd4, 32'd0, 3'b000, 4'b0100, 5'd5));
        for (int i = 0; i < 3; i++) begin
            check("ld_en_stall", 32'(bus.data_sram_en), 32'd0);
            check("ld_nr_stall", 32'(fb.not_ready), 32'd1);
            check("ld_allow_stall", 32'(bus.EX_allow_in), 32'd0);
            @(negedge clk);
        end
        bus.MEM_allow_in = 1'b1;
        #1;
        check("ld_en_accept", 32'(bus.data_sram_en), 32'd1);
        check("ld_we", 32'(bus.data_sram_we), 32'd0);
        check("ld_addr", bus.data_sram_addr, 32'h2004);
        check("ld_nr_accept", 32'(fb.not_ready), 32'd1);
        check("ld_fwd_dest", 32'(fb.dest), 32'd5);
        @(negedge clk);
        check("ld_en_after", 32'(bus.data_sram_en), 32'd0);

        // reset in the middle of a division
        issue(mk(-1, DIV_W, 32'd100, 32'd3, 32'd0, 3'b000, 4'b0000, 5'd6));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.EX_to_MEM_valid), 32'd0);
        check("mid_rst_allow", 32'(bus.EX_allow_in), 32'd1);
        check("mid_rst_fwd_dest", 32'(fb.dest), 32'd0);
        check("mid_rst_fwd_nr", 32'(fb.not_ready), 32'd0);
        reset = 1'b0;
        issue(mk(ALU_ADD, -1, 32'd1, 32'd2, 32'd0, 3'b000, 4'b0000, 5'd7));
        check("post_rst_add", mb.result, 32'd3);
        check("post_rst_valid", 32'(bus.EX_to_MEM_valid), 32'd1);
        check("post_rst_allow", 32'(bus.EX_allow_in), 32'd1);
        run_div("post_rst_divwu", DIV_WU, 32'd100, 32'd7, 32'd14);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
